// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the EX stage.
// Holds the ALU operation codes, md_op and br_op encodings, the EX FSM
// state type, the B operand select constants and a small decode helper.
package ex_pkg;

  // ALU operation codes, matching the existing ALU encoding.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // B operand source select.
  localparam logic B_SEL_RD2 = 1'b0;
  localparam logic B_SEL_EXT = 1'b1;

  typedef enum logic [2:0] {
    MD_MUL   = 3'd0,
    MD_MULH  = 3'd1,
    MD_MULHU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_REM   = 3'd5,
    MD_REMU  = 3'd6
  } md_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4,
    BR_LTU  = 3'd5,
    BR_GEU  = 3'd6
  } br_op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    MD_RUN = 1'b1
  } ex_state_e;

  function automatic logic md_is_mul(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHU);
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter: iterative multiply/divide datapath, one bit per cycle.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   abort         drops the operation in progress
//   start         one-cycle pulse loading op/a/b and starting XLEN iterations
//   op, a, b      operation and operands, sampled on start
//   done          high during the last iteration cycle
//   result        final result, valid while done is high
// Multiply is radix-2 shift-add on magnitudes; divide is restoring on
// magnitudes. Signs, divide-by-zero and signed overflow are fixed up here.
module ex_muldiv_iter
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  md_op_e          op_q, op_d;
  logic            run_q, run_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d, a_q, a_d;
  logic            neg_q, neg_d, sa_q, sa_d, dz_q, dz_d, ovf_q, ovf_d;

  logic            signed_start, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   sum, trial;
  logic [XLEN-1:0] diff_lo, hi_step, lo_step;
  logic            ge;
  logic [2*XLEN-1:0] prod, prod_fix;

  // One iteration step. Mul: hi accumulates, lo shifts out multiplier bits.
  // Div: {hi, lo} shifts left, hi holds the partial remainder, lo collects
  // quotient bits.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    trial   = {hi_q, lo_q[XLEN-1]};
    ge      = trial >= {1'b0, dvs_q};
    diff_lo = trial[XLEN-1:0] - dvs_q;
    if (md_is_mul(op_q)) begin
      hi_step = sum[XLEN:1];
      lo_step = {sum[0], lo_q[XLEN-1:1]};
    end else begin
      hi_step = ge ? diff_lo : trial[XLEN-1:0];
      lo_step = {lo_q[XLEN-2:0], ge};
    end
    prod     = {hi_step, lo_step};
    prod_fix = neg_q ? -prod : prod;
  end

  // Result taken from the step outputs so the last iteration lands directly.
  always_comb begin
    result = '0;
    unique case (op_q)
      MD_MUL:   result = prod_fix[XLEN-1:0];
      MD_MULH:  result = prod_fix[2*XLEN-1:XLEN];
      MD_MULHU: result = hi_step;
      MD_DIV:   result = dz_q ? '1 : (ovf_q ? a_q : (neg_q ? -lo_step : lo_step));
      MD_DIVU:  result = dz_q ? '1 : lo_step;
      MD_REM:   result = dz_q ? a_q : (ovf_q ? '0 : (sa_q ? -hi_step : hi_step));
      MD_REMU:  result = dz_q ? a_q : hi_step;
      default:  result = '0;
    endcase
  end

  assign done = run_q && (cnt_q == CW'(XLEN-1));

  always_comb begin
    signed_start = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    a_neg = signed_start & a[XLEN-1];
    b_neg = signed_start & b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;

    op_d  = op_q;
    run_d = run_q;
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    dvs_d = dvs_q;
    a_d   = a_q;
    neg_d = neg_q;
    sa_d  = sa_q;
    dz_d  = dz_q;
    ovf_d = ovf_q;

    if (abort) begin
      run_d = 1'b0;
    end else if (start) begin
      op_d  = md_op_e'(op);
      run_d = 1'b1;
      cnt_d = '0;
      hi_d  = '0;
      lo_d  = a_mag;
      dvs_d = b_mag;
      a_d   = a;
      neg_d = a_neg ^ b_neg;
      sa_d  = a_neg;
      dz_d  = (b == '0);
      ovf_d = (a == MIN_VAL) && (b == '1);
    end else if (run_q) begin
      hi_d  = hi_step;
      lo_d  = lo_step;
      cnt_d = cnt_q + CW'(1);
      if (done) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= MD_MUL;
      run_q <= 1'b0;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      dvs_q <= '0;
      a_q   <= '0;
      neg_q <= 1'b0;
      sa_q  <= 1'b0;
      dz_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      op_q  <= op_d;
      run_q <= run_d;
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      dvs_q <= dvs_d;
      a_q   <= a_d;
      neg_q <= neg_d;
      sa_q  <= sa_d;
      dz_q  <= dz_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/ex_stage_mc.sv
// ex_stage_mc: registered execute stage with single-cycle ALU, branch flag
// and iterative multiply/divide, valid/ready on both sides.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   flush                        drops the in-flight op and pending result
//   in_valid/in_ready            upstream handshake
//   alu_op, md_en, md_op, b_sel, br_op, A, sext_ext, rf_rD2   op fields
//   out_valid/out_ready          downstream handshake
//   C, f                         registered result and branch-taken flag
//   busy                         multiply/divide iteration in progress
// XLEN must be at least 8 and even.
// Macro EX_FAST_MUL_EN: when defined, MUL/MULH/MULHU use a combinational
// product and complete in one cycle; divides remain iterative.
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4,
  parameter int BR_OP_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic                md_en,
  input  logic [2:0]          md_op,
  input  logic                b_sel,
  input  logic [BR_OP_W-1:0]  br_op,
  input  logic [XLEN-1:0]     A,
  input  logic [XLEN-1:0]     sext_ext,
  input  logic [XLEN-1:0]     rf_rD2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     C,
  output logic                f,
  output logic                busy
);

  localparam int SHW = $clog2(XLEN);

  ex_state_e       state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] c_q, c_d;
  logic            f_q, f_d;

  logic [XLEN-1:0] b_val, alu_res, md_result, fast_res;
  logic [XLEN:0]   cmp_diff;
  logic            eq, lt_s, ltu, br_taken, accept, md_start, md_done, fast_mul;

  assign b_val    = (b_sel == B_SEL_EXT) ? sext_ext : rf_rD2;
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // One full-width A-B subtraction feeds SUB, SLT/SLTU and every branch test.
  // Borrow out gives unsigned less-than; signed less-than uses the operand
  // signs when they differ, since the difference can overflow then.
  always_comb begin
    cmp_diff = {1'b0, A} - {1'b0, b_val};
    eq       = (cmp_diff[XLEN-1:0] == '0);
    ltu      = cmp_diff[XLEN];
    lt_s     = (A[XLEN-1] ^ b_val[XLEN-1]) ? A[XLEN-1] : cmp_diff[XLEN-1];
    br_taken = 1'b0;
    case (br_op)
      BR_OP_W'(BR_EQ):  br_taken = eq;
      BR_OP_W'(BR_NE):  br_taken = !eq;
      BR_OP_W'(BR_LT):  br_taken = lt_s;
      BR_OP_W'(BR_GE):  br_taken = !lt_s;
      BR_OP_W'(BR_LTU): br_taken = ltu;
      BR_OP_W'(BR_GEU): br_taken = !ltu;
      default:          br_taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_OP_W'(ALU_ADD):   alu_res = A + b_val;
      ALU_OP_W'(ALU_SUB):   alu_res = cmp_diff[XLEN-1:0];
      ALU_OP_W'(ALU_AND):   alu_res = A & b_val;
      ALU_OP_W'(ALU_OR):    alu_res = A | b_val;
      ALU_OP_W'(ALU_XOR):   alu_res = A ^ b_val;
      ALU_OP_W'(ALU_SLL):   alu_res = A << b_val[SHW-1:0];
      ALU_OP_W'(ALU_SRL):   alu_res = A >> b_val[SHW-1:0];
      ALU_OP_W'(ALU_SRA):   alu_res = $signed(A) >>> b_val[SHW-1:0];
      ALU_OP_W'(ALU_SLT):   alu_res = {{(XLEN-1){1'b0}}, lt_s};
      ALU_OP_W'(ALU_SLTU):  alu_res = {{(XLEN-1){1'b0}}, ltu};
      ALU_OP_W'(ALU_PASSB): alu_res = b_val;
      default:              alu_res = '0;
    endcase
  end

`ifdef EX_FAST_MUL_EN
  logic              fast_signed;
  logic [2*XLEN-1:0] fast_prod;

  // Sign-extending to 2*XLEN makes the truncated product correct for MULH.
  always_comb begin
    fast_signed = (md_op == MD_MULH);
    fast_prod   = {{XLEN{fast_signed & A[XLEN-1]}}, A} *
                  {{XLEN{fast_signed & b_val[XLEN-1]}}, b_val};
    fast_mul    = md_en && md_is_mul(md_op);
    fast_res    = (md_op == MD_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`else
  always_comb begin
    fast_mul = 1'b0;
    fast_res = '0;
  end
`endif

  ex_muldiv_iter #(
    .XLEN(XLEN)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .abort (flush),
    .start (md_start),
    .op    (md_op),
    .a     (A),
    .b     (b_val),
    .done  (md_done),
    .result(md_result)
  );

  // A pending result clears when consumed; flush overrides everything and
  // in_ready already excludes a same-cycle accept.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    c_d         = c_q;
    f_d         = f_q;
    md_start    = 1'b0;
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (md_en && !fast_mul) begin
              md_start = 1'b1;
              state_d  = MD_RUN;
            end else begin
              out_valid_d = 1'b1;
              c_d         = md_en ? fast_res : alu_res;
              f_d         = md_en ? 1'b0 : br_taken;
            end
          end
        end
        MD_RUN: begin
          if (md_done) begin
            out_valid_d = 1'b1;
            c_d         = md_result;
            f_d         = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      f_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      f_q         <= f_d;
    end
  end

  assign out_valid = out_valid_q;
  assign C         = c_q;
  assign f         = f_q;
  assign busy      = (state_q == MD_RUN);

endmodule

// File: tb/tb_ex_stage_mc.sv
// tb_ex_stage_mc: directed and randomized checks of ex_stage_mc against an
// arithmetic reference model. Honours EX_FAST_MUL_EN for multiply latency.
module tb_ex_stage_mc;
  import ex_pkg::*;

  localparam int XLEN = 32;
`ifdef EX_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, md_en, b_sel;
  logic        out_valid, out_ready, f, busy;
  logic [3:0]  alu_op;
  logic [2:0]  md_op, br_op;
  logic [31:0] A, sext_ext, rf_rD2, C;

  int pass_count  = 0;
  int check_count = 0;

  ex_stage_mc #(
    .XLEN(XLEN),
    .ALU_OP_W(4),
    .BR_OP_W(3)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .md_en(md_en), .md_op(md_op), .b_sel(b_sel), .br_op(br_op),
    .A(A), .sext_ext(sext_ext), .rf_rD2(rf_rD2),
    .out_valid(out_valid), .out_ready(out_ready),
    .C(C), .f(f), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_count++;
    assert (obs === exp) begin
      pass_count++;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {f, C} from plain arithmetic on the operands.
  function automatic logic [32:0] refModel(input bit md, input logic [2:0] mop,
                                           input logic [3:0] aop, input logic [2:0] bop,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [31:0]     c;
    logic            t;
    longint          sa, sb, sp;
    longint unsigned up;
    int              ai, bi;
    sa = $signed(a);
    sb = $signed(b);
    ai = $signed(a);
    bi = $signed(b);
    up = {32'b0, a} * {32'b0, b};
    sp = sa * sb;
    c  = '0;
    t  = 1'b0;
    if (md) begin
      case (mop)
        MD_MUL:   c = up[31:0];
        MD_MULH:  c = sp[63:32];
        MD_MULHU: c = up[63:32];
        MD_DIV:   c = (b == 0) ? 32'hFFFF_FFFF :
                      ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(ai / bi));
        MD_DIVU:  c = (b == 0) ? 32'hFFFF_FFFF : a / b;
        MD_REM:   c = (b == 0) ? a :
                      ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(ai % bi));
        MD_REMU:  c = (b == 0) ? a : a % b;
        default:  c = '0;
      endcase
    end else begin
      case (aop)
        ALU_ADD:   c = a + b;
        ALU_SUB:   c = a - b;
        ALU_AND:   c = a & b;
        ALU_OR:    c = a | b;
        ALU_XOR:   c = a ^ b;
        ALU_SLL:   c = a << b[4:0];
        ALU_SRL:   c = a >> b[4:0];
        ALU_SRA:   c = $signed(a) >>> b[4:0];
        ALU_SLT:   c = (ai < bi) ? 32'd1 : 32'd0;
        ALU_SLTU:  c = (a < b) ? 32'd1 : 32'd0;
        ALU_PASSB: c = b;
        default:   c = '0;
      endcase
      case (bop)
        BR_EQ:   t = (a == b);
        BR_NE:   t = (a != b);
        BR_LT:   t = (ai < bi);
        BR_GE:   t = (ai >= bi);
        BR_LTU:  t = (a < b);
        BR_GEU:  t = (a >= b);
        default: t = 1'b0;
      endcase
    end
    return {t, c};
  endfunction

  task automatic applyStimulus(input bit md, input logic [2:0] mop, input logic [3:0] aop,
                               input bit bsel, input logic [2:0] bop,
                               input logic [31:0] a, input logic [31:0] ext, input logic [31:0] rd2);
    bit accepted = 1'b0;
    md_en = md; md_op = mop; alu_op = aop; b_sel = bsel; br_op = bop;
    A = a; sext_ext = ext; rf_rD2 = rd2; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (in_ready) begin
        accepted = 1'b1;
        tick();
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    checkOutput("accept", accepted, 1);
  endtask

  task automatic waitResult(output int lat, output int busy_n);
    lat = 1;
    busy_n = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_n++;
      tick();
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input bit md, input logic [2:0] mop, input logic [3:0] aop,
                       input bit bsel, input logic [2:0] bop,
                       input logic [31:0] a, input logic [31:0] ext, input logic [31:0] rd2);
    logic [32:0] e;
    int lat, bn, elat;
    e = refModel(md, mop, aop, bop, a, bsel ? ext : rd2);
    elat = (md && !(FAST_MUL && md_is_mul(mop))) ? XLEN + 1 : 1;
    applyStimulus(md, mop, aop, bsel, bop, a, ext, rd2);
    waitResult(lat, bn);
    checkOutput({tag, "_lat"}, lat, elat);
    checkOutput({tag, "_busy"}, bn, elat - 1);
    checkOutput({tag, "_c"}, C, e[31:0]);
    checkOutput({tag, "_f"}, f, e[32]);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  logic [3:0]  b2b_ops [4];
  logic [31:0] b2b_a [4];
  logic [31:0] b2b_b [4];
  logic [31:0] b2b_exp [4];
  logic [32:0] e1, e2;
  logic [31:0] ra, rb, rext;
  int          valid_seen;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; md_en = 1'b0; b_sel = B_SEL_RD2;
    out_ready = 1'b1; alu_op = ALU_ADD; md_op = MD_MUL; br_op = BR_NONE;
    A = '0; sext_ext = '0; rf_rD2 = '0;
    repeat (3) tick();
    rst = 1'b0;
    $display("[TB] reset released");
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_c", C, 0);
    checkOutput("rst_f", f, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_in_ready", in_ready, 1);

    runOp("add", 0, MD_MUL, ALU_ADD, B_SEL_RD2, BR_NONE, 32'd5, 32'd99, 32'd7);
    checkOutput("add_const", C, 32'd12);

    b2b_ops[0] = ALU_ADD; b2b_ops[1] = ALU_SUB; b2b_ops[2] = ALU_XOR; b2b_ops[3] = ALU_SLL;
    for (int i = 0; i < 4; i++) begin
      b2b_a[i] = $urandom;
      b2b_b[i] = $urandom;
      e1 = refModel(0, MD_MUL, b2b_ops[i], BR_NONE, b2b_a[i], b2b_b[i]);
      b2b_exp[i] = e1[31:0];
    end
    for (int i = 0; i < 4; i++) begin
      md_en = 1'b0; alu_op = b2b_ops[i]; A = b2b_a[i]; rf_rD2 = b2b_b[i];
      b_sel = B_SEL_RD2; br_op = BR_NONE; in_valid = 1'b1;
      #1;
      if (i > 0) begin
        checkOutput("b2b_valid", out_valid, 1);
        checkOutput("b2b_c", C, b2b_exp[i-1]);
      end
      checkOutput("b2b_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    checkOutput("b2b_valid_last", out_valid, 1);
    checkOutput("b2b_c_last", C, b2b_exp[3]);

    runOp("blt", 0, MD_MUL, ALU_SUB, B_SEL_RD2, BR_LT, 32'hFFFF_FFFF, 32'd0, 32'd1);
    checkOutput("blt_const", f, 1);
    runOp("bltu", 0, MD_MUL, ALU_SUB, B_SEL_RD2, BR_LTU, 32'hFFFF_FFFF, 32'd0, 32'd1);
    checkOutput("bltu_const", f, 0);
    runOp("bnone", 0, MD_MUL, ALU_SUB, B_SEL_EXT, BR_NONE, 32'hFFFF_FFFF, 32'd1, 32'd0);
    checkOutput("bnone_const", f, 0);

    runOp("div", 1, MD_DIV, ALU_ADD, B_SEL_RD2, BR_EQ, 32'hFFFF_FFF9, 32'd0, 32'd2);
    checkOutput("div_const", C, 32'hFFFF_FFFD);
    runOp("rem", 1, MD_REM, ALU_ADD, B_SEL_RD2, BR_NONE, 32'hFFFF_FFF9, 32'd0, 32'd2);
    checkOutput("rem_const", C, 32'hFFFF_FFFF);
    runOp("divu0", 1, MD_DIVU, ALU_ADD, B_SEL_EXT, BR_NONE, 32'd1234, 32'd0, 32'd5);
    checkOutput("divu0_const", C, 32'hFFFF_FFFF);
    runOp("removf", 1, MD_REM, ALU_ADD, B_SEL_RD2, BR_NONE, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF);
    checkOutput("removf_const", C, 32'h0);
    runOp("divovf", 1, MD_DIV, ALU_ADD, B_SEL_RD2, BR_NONE, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF);
    checkOutput("divovf_const", C, 32'h8000_0000);
    runOp("mulh", 1, MD_MULH, ALU_ADD, B_SEL_RD2, BR_NONE, 32'h8000_0000, 32'd0, 32'd2);
    checkOutput("mulh_const", C, 32'hFFFF_FFFF);

    // Output hold with downstream stalled.
    tick();
    out_ready = 1'b0;
    e1 = refModel(0, MD_MUL, ALU_XOR, BR_NONE, 32'h1234_5678, 32'h0F0F_0F0F);
    e2 = refModel(0, MD_MUL, ALU_ADD, BR_NONE, 32'd100, 32'd23);
    applyStimulus(0, MD_MUL, ALU_XOR, B_SEL_RD2, BR_NONE, 32'h1234_5678, 32'd0, 32'h0F0F_0F0F);
    md_en = 1'b0; alu_op = ALU_ADD; A = 32'd100; rf_rD2 = 32'd23; b_sel = B_SEL_RD2;
    br_op = BR_NONE; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_c", C, e1[31:0]);
      checkOutput("hold_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("hold_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    checkOutput("hold_next_valid", out_valid, 1);
    checkOutput("hold_next_c", C, e2[31:0]);

    // Flush on iteration cycle 10 of a divide, with a competing input.
    applyStimulus(1, MD_DIV, ALU_ADD, B_SEL_RD2, BR_NONE, 32'hFFFF_FFF9, 32'd0, 32'd2);
    repeat (9) tick();
    checkOutput("flush_busy_pre", busy, 1);
    flush = 1'b1; md_en = 1'b0; alu_op = ALU_ADD; A = 32'd1; rf_rD2 = 32'd1; in_valid = 1'b1;
    #1;
    checkOutput("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush_out_valid", out_valid, 0);
    checkOutput("flush_busy", busy, 0);
    valid_seen = 0;
    repeat (40) begin
      if (out_valid) valid_seen++;
      tick();
    end
    checkOutput("flush_no_result", valid_seen, 0);

    // Same scenario with reset instead of flush.
    runOp("pre_rst", 0, MD_MUL, ALU_ADD, B_SEL_RD2, BR_EQ, 32'd6, 32'd0, 32'd6);
    applyStimulus(1, MD_DIV, ALU_ADD, B_SEL_RD2, BR_NONE, 32'hFFFF_FFF9, 32'd0, 32'd2);
    repeat (9) tick();
    rst = 1'b1; md_en = 1'b0; A = 32'd1; rf_rD2 = 32'd1; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    checkOutput("mrst_out_valid", out_valid, 0);
    checkOutput("mrst_c", C, 0);
    checkOutput("mrst_f", f, 0);
    checkOutput("mrst_busy", busy, 0);
    valid_seen = 0;
    repeat (40) begin
      if (out_valid) valid_seen++;
      tick();
    end
    checkOutput("mrst_no_result", valid_seen, 0);

    // Randomized mix against the reference model.
    for (int i = 0; i < 150; i++) begin
      ra   = pickOperand();
      rb   = pickOperand();
      rext = pickOperand();
      runOp("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 6)),
            4'($urandom_range(0, 10)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 6)), ra, rext, rb);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/ex_stage_mc.md
Name: ex_stage_mc

Overview:
- Parametrised, registered execute stage for the RV32-style core.
- Single-cycle ALU path plus an iterative multiply/divide path (M-extension subset).
- Real branch-condition flag output.
- Sits between the ID/EX and EX/MEM registers, with valid/ready handshakes on both sides so multi-cycle ops stall the front end.

Parameters:
- XLEN, 32, datapath width; must be ≥ 8 and even.
- ALU_OP_W, 4, width of alu_op.
- BR_OP_W, 3, width of br_op.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard in-flight and pending-output op
- in_valid  in  1  upstream op valid
- in_ready  out  1  stage can accept op
- alu_op  in  ALU_OP_W  ALU operation (existing ALU encodings)
- md_en  in  1  op is mul/div; selects MD path over ALU
- md_op  in  3  MUL, MULH, MULHU, DIV, DIVU, REM, REMU
- b_sel  in  1  B operand source: rf_rD2 or sext_ext
- br_op  in  BR_OP_W  NONE, EQ, NE, LT, GE, LTU, GEU
- A  in  XLEN  operand A
- sext_ext  in  XLEN  immediate
- rf_rD2  in  XLEN  register operand 2
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- C  out  XLEN  result
- f  out  1  branch taken
- busy  out  1  MD iteration in progress

Behaviour:
- Reset: state IDLE; out_valid=0, C=0, f=0, busy=0; all iteration registers cleared.
- B = b_sel ? sext_ext : rf_rD2.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Accept happens when in_valid && in_ready.
- ALU op (md_en=0), accepted at cycle T:
  - C = ALU(A,B) and f = branch condition, both registered.
  - out_valid=1 at T+1.
- Branch flag: uses full A−B compare.
  - EQ/NE: equality.
  - LT/GE: signed.
  - LTU/GEU: unsigned.
  - NONE gives f=0. f=0 for all MD ops.
- MD op (md_en=1), accepted at cycle T:
  - State MD_RUN with busy=1 for exactly XLEN cycles, then result registered.
  - out_valid=1 at T+XLEN+1.
- Multiply: radix-2 shift-add over |operands| with 2·XLEN product.
  - MUL returns low half.
  - MULH returns high half, signed×signed (sign fix-up at end).
  - MULHU returns high half, unsigned.
- Divide: restoring, one quotient bit per cycle on magnitudes. Quotient sign = sign(A)^sign(B); remainder sign = sign(A).
- Divide by zero: DIV/DIVU return all-ones; REM/REMU return A. Still take the full XLEN cycles.
- Signed overflow (A=−2^(XLEN−1), B=−1): DIV returns A; REM returns 0.
- States: IDLE → MD_RUN on MD accept. MD_RUN → IDLE after counter reaches XLEN−1, writing the result.
- Output hold: while out_valid && !out_ready, C and f are stable and in_ready=0.
- Back-to-back ALU ops with out_ready=1 sustain one result per cycle.
- flush: next cycle state=IDLE, out_valid=0, busy=0.
  - In-flight MD op is dropped with no result.
  - A same-cycle in_valid is not accepted (flush wins).
- rst mid-iteration: identical to reset; no partial result is emitted.

Optional Feature:
- Macro: EX_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHU use a combinational XLEN×XLEN product and complete like ALU ops (out_valid at T+1, busy stays 0).
  - Divides stay iterative.
- Undefined: all MD ops are iterative as above.

Decomposition:
- Package ex_pkg holds:
  - md_op and br_op encodings;
  - FSM state encoding (IDLE, MD_RUN);
  - B_SEL constants, kept consistent with existing defines.
- Sub-module ex_muldiv_iter holds:
  - iterative mul/div datapath: counter, accumulators, sign fix-up;
  - start/done pulse interface;
  - owns the div-by-zero and overflow rules.
- ex_stage_mc holds the handshake, FSM, the existing ALU instance, and the branch compare.

Test Plan:
- ALU add, A=5, rf_rD2=7, b_sel=RD2, out_ready=1 → C=12 one cycle after accept; 4 back-to-back ops give 4 consecutive valid results.
- BLT, A=0xFFFFFFFF, B=1, br_op=LT → f=1; same operands with LTU → f=0; br_op=NONE → f=0.
- DIV, A=−7, B=2 → C=0xFFFFFFFD at T+33, busy high 32 cycles; REM same operands → C=0xFFFFFFFF; DIVU by 0 → 0xFFFFFFFF; REM 0x80000000/−1 → 0.
- MULH, A=0x80000000, B=2 → C=0xFFFFFFFF. With EX_FAST_MUL_EN → valid at T+1; without → valid at T+33.
- Hold ALU result with out_ready=0 for 5 cycles → C stable, in_ready=0; raise out_ready → next op accepted the same cycle.
- Assert flush on cycle 10 of a DIV, with in_valid=1 the same cycle → no out_valid, busy=0 next cycle, that input not accepted. Repeat with rst instead → all outputs 0.
